// File: rtl/mpe_stream_src.sv
// Operand streamer: reads a burst of DATA_W words from a 1-cycle-latency SRAM
// and presents them on a valid/ready stream feeding one matrix_pe operand port.
module mpe_stream_src #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued_q;
    logic [LEN_W-1:0]  accepted_q;
    logic              in_flight_q;
    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              done_q;

    logic       cmd_hs;
    logic       push;
    logic       pop;
    logic       issue_ok;
    logic       issue_last;
    logic       pop_last;
    logic [2:0] load;

    // A transfer happens on a rising edge where valid & ready are both high.
    // Once valid is raised it and its data hold until that transfer; valid
    // never looks at ready, and cmd_ready never looks at cmd_valid.
    assign cmd_hs    = cmd_valid & cmd_ready;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = fifo_mem[rd_ptr_q];
    assign pop       = out_valid & out_ready;
    assign push      = in_flight_q;

    // FIFO slots plus the read in flight may never exceed the two entries.
    assign load     = {1'b0, count_q} + {2'b00, in_flight_q};
    assign issue_ok = (load < 3'd2) || ((load == 3'd2) && pop);

    assign issue_last  = ram_rd_en && (issued_q == len_q - LEN_W'(1));
    assign pop_last    = pop && (state == DRAIN) && (accepted_q == len_q - LEN_W'(1));
    assign ram_rd_addr = addr_q;
    assign done        = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_hs && (cmd_len != '0)) state_nxt = RUN;
            RUN:     if (issue_last)                state_nxt = DRAIN;
            DRAIN:   if (pop_last)                  state_nxt = IDLE;
            default:                                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        ram_rd_en = 1'b0;
        case (state)
            IDLE:    cmd_ready = 1'b1;
            RUN:     ram_rd_en = issue_ok;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            accepted_q  <= '0;
            in_flight_q <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            done_q      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            done_q      <= (cmd_hs && (cmd_len == '0)) || pop_last;
            in_flight_q <= ram_rd_en;

            if (cmd_hs) begin
                addr_q     <= cmd_base;
                len_q      <= cmd_len;
                issued_q   <= '0;
                accepted_q <= '0;
            end else if (ram_rd_en) begin
                addr_q   <= addr_q + ADDR_W'(1);
                issued_q <= issued_q + LEN_W'(1);
            end

            if (pop) begin
                rd_ptr_q   <= ~rd_ptr_q;
                accepted_q <= accepted_q + LEN_W'(1);
            end

            if (push) begin
                fifo_mem[wr_ptr_q] <= ram_rd_data;
                wr_ptr_q           <= ~wr_ptr_q;
            end

            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_mpe_stream_src.sv
// Self-checking bench for mpe_stream_src: SRAM model, burst-level scoreboard,
// per-cycle protocol checks and directed/randomized command sequences.
module tb_mpe_stream_src;

    localparam int DATA_W = 512;
    localparam int ADDR_W = 16;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] cmd_base;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              done;

    mpe_stream_src #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_base    (cmd_base),
        .cmd_len     (cmd_len),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .done        (done)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = {a, ~a} ^ 32'hA5C3_0F96;
        return {16{w}};
    endfunction

    // SRAM model: data valid exactly one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= ram_word(ram_rd_addr);
        else           ram_rd_data <= {16{$urandom}};
    end

    // ---------------- scoreboard / reference model ----------------
    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [ADDR_W-1:0] seen_addr[$];
    logic              chk_en     = 1'b0;
    logic              busy       = 1'b0;
    logic              done_pend  = 1'b0;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic              saw_rd     = 1'b0;
    int issued = 0, popped = 0, done_cnt = 0, beats = 0;
    int acc_cyc = 0, first_rd_cyc = -1, first_val_cyc = -1, last_hs_cyc = -1;

    always @(negedge clk) begin
        if (chk_en) begin
            if (rst) begin
                exp_q.delete();
                exp_addr_q.delete();
                busy       = 1'b0;
                done_pend  = 1'b0;
                prev_stall = 1'b0;
                issued     = 0;
                popped     = 0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", out_valid, 1'b1);
                    check("hold_data", out_data, prev_data);
                end
                check("cmd_ready", cmd_ready, !busy);
                check("done", done, done_pend);
                if (done) done_cnt++;
                done_pend = 1'b0;

                saw_rd = ram_rd_en;
                if (ram_rd_en) begin
                    issued++;
                    seen_addr.push_back(ram_rd_addr);
                    if (first_rd_cyc < 0) first_rd_cyc = cyc;
                    check("read_allowed", exp_addr_q.size() > 0, 1'b1);
                    if (exp_addr_q.size() > 0) check("rd_addr", ram_rd_addr, exp_addr_q.pop_front());
                end

                if (out_valid) begin
                    if (first_val_cyc < 0) first_val_cyc = cyc;
                    check("valid_has_beat", exp_q.size() > 0, 1'b1);
                end
                if (out_valid && out_ready && exp_q.size() > 0) begin
                    check("beat_data", out_data, exp_q.pop_front());
                    popped++;
                    beats++;
                    last_hs_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        busy      = 1'b0;
                        done_pend = 1'b1;
                    end
                end
                check("occupancy", (issued - popped) <= 2, 1'b1);

                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;

                if (cmd_valid && cmd_ready) begin
                    acc_cyc       = cyc;
                    first_rd_cyc  = -1;
                    first_val_cyc = -1;
                    beats         = 0;
                    if (cmd_len == '0) begin
                        done_pend = 1'b1;
                    end else begin
                        busy = 1'b1;
                        for (int i = 0; i < int'(cmd_len); i++) begin
                            logic [ADDR_W-1:0] a;
                            a = cmd_base + ADDR_W'(i);
                            exp_q.push_back(ram_word(a));
                            exp_addr_q.push_back(a);
                        end
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    logic rnd_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // All driver tasks start and end just after a rising edge.
    task automatic send_cmd(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] l);
        int n = 0;
        cmd_base  = b;
        cmd_len   = l;
        cmd_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 5000);
        check("cmd_accept_timeout", n < 5000, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_base  = ADDR_W'($urandom);
        cmd_len   = LEN_W'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() > 0 || done_pend) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", n < 5000, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int d0;
        int n;
        logic [ADDR_W-1:0] want_addr[4];
        want_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_rd_en", ram_rd_en, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_rd_addr", ram_rd_addr, '0);
        chk_en = 1'b1;
        @(posedge clk); #1;

        // 1: len=35, ready held high
        d0 = done_cnt;
        send_cmd(16'd0, 8'd35);
        wait_idle();
        check("t1_rd_latency", first_rd_cyc - acc_cyc, 1);
        check("t1_valid_latency", first_val_cyc - acc_cyc, 3);
        check("t1_no_gaps", last_hs_cyc - first_val_cyc, 34);
        check("t1_beats", beats, 35);
        check("t1_done_last", last_hs_cyc - acc_cyc, 37);
        check("t1_done_cnt", done_cnt - d0, 1);

        // 2: len=35, random ready
        rnd_ready = 1'b1;
        d0 = done_cnt;
        send_cmd(16'd500, 8'd35);
        wait_idle();
        check("t2_beats", beats, 35);
        check("t2_done_cnt", done_cnt - d0, 1);

        // 3: len=0
        rnd_ready = 1'b0;
        d0 = done_cnt;
        n  = issued;
        send_cmd(16'h1234, 8'd0);
        wait_idle();
        check("t3_done_cnt", done_cnt - d0, 1);
        check("t3_no_reads", issued - n, 0);

        // 4: address wrap
        seen_addr.delete();
        send_cmd(16'hFFFE, 8'd4);
        wait_idle();
        check("t4_addr_cnt", seen_addr.size(), 4);
        for (int i = 0; i < 4 && i < seen_addr.size(); i++)
            check("t4_addr", seen_addr[i], want_addr[i]);

        // 5: four back-to-back len=35 commands
        rnd_ready = 1'b1;
        d0 = done_cnt;
        for (int k = 0; k < 4; k++) send_cmd(ADDR_W'(1000 + 35 * k), 8'd35);
        wait_idle();
        check("t5_done_cnt", done_cnt - d0, 4);

        // random commands, including max length
        for (int k = 0; k < 6; k++) send_cmd(ADDR_W'($urandom), LEN_W'($urandom_range(0, 40)));
        send_cmd(16'h7F00, 8'd255);
        wait_idle();

        // 6: reset mid-burst with a read in flight
        rnd_ready = 1'b0;
        d0 = done_cnt;
        send_cmd(16'd200, 8'd35);
        n = 0;
        while (!(beats >= 10 && saw_rd) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        check("t6_reach_beat10", n < 1000, 1'b1);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t6_out_valid", out_valid, 1'b0);
        check("t6_cmd_ready", cmd_ready, 1'b1);
        check("t6_done", done, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        check("t6_no_done", done_cnt - d0, 0);
        send_cmd(16'd100, 8'd2);
        wait_idle();
        check("t6_beats", beats, 2);
        check("t6_done_cnt", done_cnt - d0, 1);

        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL global_timeout: simulation did not finish by %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mpe_stream_src.md
Name: mpe_stream_src

Overview:
- Source-side streamer that feeds one matrix_pe operand port, either neuron or weight.
- Accepts a command with a base address and a beat count.
- Reads 512-bit vectors from a single-port SRAM with fixed 1-cycle read latency.
- Presents the vectors on a valid/ready stream that connects directly to nram_mpe_neuron_* or wram_mpe_weight_*.
- One instance is placed per operand RAM. The instance is the transmitter for the PE's operand receiver.

Parameters:
- DATA_W, 512: width of one operand beat.
- ADDR_W, 16: SRAM word-address width.
- LEN_W, 8: beat-count width, matching the 8-bit uop field.

Ports:
- clk, input, 1: clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- cmd_base, input, ADDR_W: first SRAM word address of the burst.
- cmd_len, input, LEN_W: number of beats in the burst; 0 is legal.
- cmd_valid, input, 1: command valid.
- cmd_ready, output, 1: block idle, command can be accepted.
- ram_rd_en, output, 1: SRAM read strobe.
- ram_rd_addr, output, ADDR_W: SRAM read address.
- ram_rd_data, input, DATA_W: SRAM read data, valid exactly 1 cycle after ram_rd_en.
- out_data, output, DATA_W: operand beat to the PE.
- out_valid, output, 1: beat valid.
- out_ready, input, 1: PE ready.
- done, output, 1: 1-cycle pulse when the burst's last beat handshakes, or when a len=0 command is accepted.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE. cmd_ready=1, out_valid=0, ram_rd_en=0, done=0.
  - out_data and ram_rd_addr are 0.
  - Buffer is emptied, in-flight read is discarded, and counters are cleared.
  - Reset mid-burst abandons the burst. No done pulse. A read returning in the cycle after reset is dropped.
- States:
  - IDLE: cmd_ready=1. A handshake (cmd_valid & cmd_ready) latches base and len.
    - len != 0 -> RUN.
    - len = 0 -> done=1 on the next cycle; stay in IDLE; no reads, no beats.
  - RUN: cmd_ready=0. Issue reads until issued count = len, then go to DRAIN.
  - DRAIN: no reads. When the handshake of beat len-1 occurs, done=1 on the next cycle and go to IDLE. cmd_ready=1 from that same cycle.
  - The transition to DRAIN may happen on the same cycle as the last issue.
- Output buffer:
  - 2-entry FIFO holding ram_rd_data. Returned data is written into it 1 cycle after ram_rd_en.
  - out_valid = FIFO not empty. out_data = FIFO head.
  - Flow control: ram_rd_en=1 only when (occupancy + in_flight) < 2, or when occupancy + in_flight = 2 and a pop happens this cycle. in_flight is 0 or 1.
  - With out_ready held high, one beat per cycle with no bubbles after the first.
  - First beat latency: cmd handshake at cycle T -> ram_rd_en at T+1 -> out_valid at T+3 (1 register stage after RAM data).
- Handshake rules:
  - Once out_valid=1, out_valid and out_data stay constant until out_valid & out_ready.
  - out_valid never depends combinationally on out_ready.
  - cmd_ready does not depend combinationally on cmd_valid.
- Address arithmetic:
  - ram_rd_addr starts at cmd_base and increments by 1 per issued read, modulo 2^ADDR_W.
  - Example: base=0xFFFF -> 0xFFFF, 0x0000, ...
- Counts: the issued and accepted counters are LEN_W bits wide. len=255 is the maximum.
- Simultaneous push and pop with the FIFO full is legal; occupancy is unchanged.
- A new command is accepted only in IDLE. cmd_valid during RUN or DRAIN is held off by cmd_ready=0.

Test Plan:
1. Reset, then cmd base=0, len=35, out_ready=1 constant.
   - 35 beats match RAM words 0..34 in order.
   - out_valid is first high 3 cycles after the cmd handshake, with no gaps.
   - done pulses once, 1 cycle after beat 34 handshakes.
2. len=35 with out_ready random 50% (the $random style used for the PE benches).
   - Data order is exact. Nothing is dropped or duplicated.
   - out_data stays stable while out_valid=1 and out_ready=0.
   - Occupancy never exceeds 2.
3. cmd len=0.
   - No ram_rd_en and no out_valid.
   - done=1 on the cycle after the handshake; cmd_ready stays 1.
4. base=0xFFFE, len=4.
   - Read addresses are 0xFFFE, 0xFFFF, 0x0000, 0x0001.
5. Four back-to-back cmds of len 35 each (140 beats total, same as the PE test set) against a matrix_pe instance plus a second mpe_stream_src.
   - All 4 PE results match the golden data.
   - Exactly 4 done pulses per instance.
6. Assert rst for 1 cycle at beat 10 of a len=35 burst while a read is in flight.
   - Next cycle: out_valid=0, cmd_ready=1, no done pulse.
   - The stale read data is not presented.
   - A new cmd base=100, len=2 yields words 100 and 101 only.
